// File: rtl/max7219_chain_if.sv
// Serial driver for a daisy chain of MAX7219 devices: shifts one masked
// 16-bit word per device, MSB first, then optionally pulses LOAD once.
module max7219_chain_if #(
    parameter int G_NB_MATRIX       = 8,
    parameter int G_MAX_HALF_PERIOD = 4,
    parameter int G_LOAD_DURATION   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_en_load,
    input  logic [16*G_NB_MATRIX-1:0] i_data,
    input  logic [G_NB_MATRIX-1:0]    i_mask,
    output logic                      o_max7219_clk,
    output logic                      o_max7219_data,
    output logic                      o_max7219_load,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_discard
);

    localparam int NB = 16 * G_NB_MATRIX;
    localparam int BW = $clog2(NB);
    localparam int HW = (G_MAX_HALF_PERIOD > 1) ? $clog2(G_MAX_HALF_PERIOD) : 1;
    localparam int LW = (G_LOAD_DURATION > 1) ? $clog2(G_LOAD_DURATION) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [NB-1:0]   shreg;
    logic [NB-1:0]   data_masked;
    logic [BW-1:0]   bit_cnt;
    logic [HW-1:0]   half_cnt;
    logic [LW-1:0]   load_cnt;
    logic            en_load_q;
    logic            discard_q;
    logic            half_last, bit_last, load_last;

    // Masked devices get an all-zero word, which the MAX7219 decodes as NO-OP.
    for (genvar k = 0; k < G_NB_MATRIX; k++) begin : g_mask
        assign data_masked[16*k +: 16] = i_mask[k] ? 16'h0000 : i_data[16*k +: 16];
    end

    assign half_last = (half_cnt == HW'(G_MAX_HALF_PERIOD - 1));
    assign bit_last  = (bit_cnt  == BW'(NB - 1));
    assign load_last = (load_cnt == LW'(G_LOAD_DURATION - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_LOW;
            S_LOW:   if (half_last) state_nxt = S_HIGH;
            S_HIGH: begin
                if (half_last) begin
                    if (!bit_last)      state_nxt = S_LOW;
                    else if (en_load_q) state_nxt = S_LOAD;
                    else                state_nxt = S_DONE;
                end
            end
            S_LOAD:  if (load_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            load_cnt  <= '0;
            en_load_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            discard_q <= i_start && (state != S_IDLE);

            // Half-period counter restarts on every state change, so it never wraps.
            if (state != state_nxt)
                half_cnt <= '0;
            else if (state == S_LOW || state == S_HIGH)
                half_cnt <= half_cnt + HW'(1);

            if (state == S_LOAD && state_nxt == S_LOAD)
                load_cnt <= load_cnt + LW'(1);
            else
                load_cnt <= '0;

            if (state == S_IDLE && i_start) begin
                shreg     <= data_masked;
                en_load_q <= i_en_load;
                bit_cnt   <= '0;
            end else if (state == S_HIGH && half_last && !bit_last) begin
                shreg   <= {shreg[NB-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    assign o_max7219_clk  = (state == S_HIGH);
    assign o_max7219_data = (state == S_LOW || state == S_HIGH) ? shreg[NB-1] : 1'b0;
    assign o_max7219_load = (state == S_LOAD);
    assign o_busy         = (state != S_IDLE);
    assign o_done         = (state == S_DONE);
    assign o_discard      = discard_q;

endmodule

// File: tb/tb_max7219_chain_if.sv
// Directed bench: 2-device chain driven from a vector table, plus a
// hand-written sequence on a 1-device chain with minimum timing.
module tb_max7219_chain_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_en_load = 1'b0;
    logic [31:0] i_data = '0;
    logic [1:0]  i_mask = '0;
    logic        m_clk, m_data, m_load, busy, done, discard;

    logic        s_start = 1'b0;
    logic        s_en_load = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_mask = 1'b0;
    logic        s_mclk, s_mdata, s_mload, s_busy, s_done, s_discard;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    max7219_chain_if #(.G_NB_MATRIX(2), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_en_load(i_en_load),
        .i_data(i_data), .i_mask(i_mask), .o_max7219_clk(m_clk),
        .o_max7219_data(m_data), .o_max7219_load(m_load), .o_busy(busy),
        .o_done(done), .o_discard(discard)
    );

    max7219_chain_if #(.G_NB_MATRIX(1), .G_MAX_HALF_PERIOD(1), .G_LOAD_DURATION(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_en_load(s_en_load),
        .i_data(s_data), .i_mask(s_mask), .o_max7219_clk(s_mclk),
        .o_max7219_data(s_mdata), .o_max7219_load(s_mload), .o_busy(s_busy),
        .o_done(s_done), .o_discard(s_discard)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mask;
        logic        en;
        int          disc_at;   // cycle to re-assert start mid-frame (0 = none)
        bit          disc_done; // re-assert start in the o_done cycle
        int          rst_at;    // cycle to assert reset (0 = none)
        logic [31:0] exp_stream;
        int          exp_bits;  // -1: stream not checked
        int          exp_done;  // -1: no o_done expected
        int          exp_load_at;
        int          exp_load;
        int          exp_disc;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int bits = 0, load_cnt = 0, load_at = -1, done_at = -1, done_cnt = 0;
        int disc_cnt = 0, viol = 0;
        logic [31:0] stream = '0;
        logic pclk = 1'b0;
        bit trig = 0;
        @(negedge clk);
        i_data = v.data; i_mask = v.mask; i_en_load = v.en; i_start = 1'b1;
        @(negedge clk);
        // Scramble inputs after capture; the frame must not notice.
        i_start = 1'b0; i_data = ~v.data; i_mask = 2'b11; i_en_load = ~v.en;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge clk);
            if (trig) begin i_start = 1'b0; trig = 0; end
            if (c == 1) chk($sformatf("v%0d busy_c1", idx), busy, 1);
            if (m_clk && !pclk) begin stream = {stream[30:0], m_data}; bits++; end
            pclk = m_clk;
            if (m_load) begin
                load_cnt++;
                if (load_at < 0) load_at = c;
                if (m_clk || m_data) viol++;
            end
            if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
            if (discard) disc_cnt++;
            if (v.disc_at == c) begin i_start = 1'b1; trig = 1; end
            if (v.disc_done && done) begin i_start = 1'b1; trig = 1; end
            if (v.rst_at == c) begin
                rst_n = 1'b0;
                #1 chk($sformatf("v%0d rst_outs", idx),
                       {m_clk, m_data, m_load, busy, done, discard}, 0);
            end
            if (v.rst_at > 0 && c == v.rst_at + 3) rst_n = 1'b1;
        end
        chk($sformatf("v%0d busy_end", idx), busy, 0);
        if (v.exp_bits >= 0) begin
            chk($sformatf("v%0d bits", idx), bits, v.exp_bits);
            chk($sformatf("v%0d stream", idx), stream, v.exp_stream);
        end
        chk($sformatf("v%0d done_at", idx), done_at, v.exp_done);
        chk($sformatf("v%0d done_cnt", idx), done_cnt, (v.exp_done < 0) ? 0 : 1);
        chk($sformatf("v%0d load_at", idx), load_at, v.exp_load_at);
        chk($sformatf("v%0d load_len", idx), load_cnt, v.exp_load);
        chk($sformatf("v%0d discard", idx), disc_cnt, v.exp_disc);
        chk($sformatf("v%0d load_viol", idx), viol, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0C01_0F00, 2'b00, 1'b1, 0,  0, 0,   32'h0C01_0F00, 32, 261, 257, 4, 0};
        vecs[1] = '{32'h0C01_0F00, 2'b10, 1'b1, 0,  0, 0,   32'h0000_0F00, 32, 261, 257, 4, 0};
        vecs[2] = '{32'h0C01_0F00, 2'b00, 1'b0, 0,  0, 0,   32'h0C01_0F00, 32, 257, -1,  0, 0};
        vecs[3] = '{32'h0C01_0F00, 2'b00, 1'b1, 50, 1, 0,   32'h0C01_0F00, 32, 261, 257, 4, 2};
        vecs[4] = '{32'h0C01_0F00, 2'b00, 1'b1, 0,  0, 100, 32'h0,         -1, -1,  -1,  0, 0};
        vecs[5] = '{32'h1234_8001, 2'b01, 1'b1, 0,  0, 0,   32'h1234_0000, 32, 261, 257, 4, 0};

        #12;
        chk("reset_outs", {m_clk, m_data, m_load, busy, done, discard}, 0);
        chk("reset_outs1", {s_mclk, s_mdata, s_mload, s_busy, s_done, s_discard}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Single device, shortest timing: 2-cycle bit period, 1-cycle LOAD.
        begin
            int bits = 0, load_cnt = 0, load_at = -1, done_at = -1;
            logic [15:0] stream = '0;
            logic pclk = 1'b0;
            @(negedge clk);
            s_data = 16'hA55A; s_mask = 1'b0; s_en_load = 1'b1; s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0; s_data = 16'hFFFF;
            for (int c = 1; c <= 50; c++) begin
                if (c > 1) @(negedge clk);
                if (s_mclk && !pclk) begin stream = {stream[14:0], s_mdata}; bits++; end
                pclk = s_mclk;
                if (s_mload) begin load_cnt++; if (load_at < 0) load_at = c; end
                if (s_done && done_at < 0) done_at = c;
            end
            chk("n1 bits", bits, 16);
            chk("n1 stream", stream, 16'hA55A);
            chk("n1 done_at", done_at, 34);
            chk("n1 load_at", load_at, 33);
            chk("n1 load_len", load_cnt, 1);
            chk("n1 busy_end", s_busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
